// File: rtl/maxi_pkg.sv
// maxi_pkg: FSM state encoding and the sample compare helper shared by
// stream_maxi and maxi_lane_tree.
package maxi_pkg;

    // Widest sample the compare helper handles.
    localparam int MAX_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } maxi_state_e;

    // Strict a > b over the low `width` bits (upper bits must be zero).
    // In signed mode the sign bit is inverted on both operands, which maps
    // two's-complement order onto plain unsigned order.
    function automatic logic is_greater(input logic [MAX_DATA_W-1:0] a,
                                        input logic [MAX_DATA_W-1:0] b,
                                        input int                    width,
                                        input logic                  signed_mode);
        logic [MAX_DATA_W-1:0] sign_bit;
        logic [MAX_DATA_W-1:0] ua;
        logic [MAX_DATA_W-1:0] ub;
        sign_bit = MAX_DATA_W'(1) << (width - 1);
        ua       = signed_mode ? (a ^ sign_bit) : a;
        ub       = signed_mode ? (b ^ sign_bit) : b;
        return ua > ub;
    endfunction

endpackage

// File: rtl/maxi_lane_tree.sv
// maxi_lane_tree: combinational LANES-input max tree. With MAXI_ARGMAX_EN
// defined it also reports the lane holding the maximum; on ties the lower
// lane wins.
module maxi_lane_tree
    import maxi_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SIGNED     = 0
`ifdef MAXI_ARGMAX_EN
    ,
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
`endif
) (
    input  logic [LANES*DATA_WIDTH-1:0] lane_data,
    output logic [DATA_WIDTH-1:0]       beat_max
`ifdef MAXI_ARGMAX_EN
    ,
    output logic [LANE_W-1:0]           beat_lane
`endif
);

    localparam int LEVELS = $clog2(LANES);

    // Pairwise reduction: each node keeps its left (lower) child unless the
    // right child is strictly greater. Node k of a level lands in slot k,
    // which the loop has already consumed, so the reduction runs in place.
    always_comb begin
        logic [DATA_WIDTH-1:0] val [LANES];
`ifdef MAXI_ARGMAX_EN
        logic [LANE_W-1:0]     idx [LANES];
`endif
        // NOTE: every temporary and output is written unconditionally before
        // any branch, so no path leaves a value held and no latch is inferred.
        for (int k = 0; k < LANES; k++) begin
            val[k] = lane_data[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef MAXI_ARGMAX_EN
            idx[k] = LANE_W'(k);
`endif
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = 0; k < (LANES >> (l + 1)); k++) begin
                if (is_greater(MAX_DATA_W'(val[2*k+1]), MAX_DATA_W'(val[2*k]),
                               DATA_WIDTH, SIGNED != 0)) begin
                    val[k] = val[2*k+1];
`ifdef MAXI_ARGMAX_EN
                    idx[k] = idx[2*k+1];
`endif
                end else begin
                    val[k] = val[2*k];
`ifdef MAXI_ARGMAX_EN
                    idx[k] = idx[2*k];
`endif
                end
            end
        end
        beat_max  = val[0];
`ifdef MAXI_ARGMAX_EN
        beat_lane = idx[0];
`endif
    end

endmodule

// File: rtl/stream_maxi.sv
// stream_maxi: frame maximum over a LANES-wide sample stream.
// Each frame of N samples arrives as N/LANES beats; one result per frame is
// held on out_max until the consumer takes it. Define MAXI_ARGMAX_EN to add
// out_index (frame position of the first maximum) and its index logic.
module stream_maxi
    import maxi_pkg::*;
#(
    parameter int N          = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int SIGNED     = 0
`ifdef MAXI_ARGMAX_EN
    ,
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
`endif
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_max
`ifdef MAXI_ARGMAX_EN
    ,
    output logic [IDX_W-1:0]            out_index
`endif
);

    localparam int BEATS  = N / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef MAXI_ARGMAX_EN
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
`endif

    maxi_state_e           state;
    maxi_state_e           state_next;
    logic [BEAT_W-1:0]     beat_count;
    logic [DATA_WIDTH-1:0] acc_max;
    logic [DATA_WIDTH-1:0] beat_max;
    logic [DATA_WIDTH-1:0] next_max;
    logic                  beat_fire;
    logic                  last_beat;
    logic                  take_beat;
`ifdef MAXI_ARGMAX_EN
    logic [IDX_W-1:0]      acc_index;
    logic [IDX_W-1:0]      next_index;
    logic [LANE_W-1:0]     beat_lane;
`endif

    maxi_lane_tree #(
        .LANES      (LANES),
        .DATA_WIDTH (DATA_WIDTH),
        .SIGNED     (SIGNED)
    ) u_tree (
        .lane_data  (in_data),
        .beat_max   (beat_max)
`ifdef MAXI_ARGMAX_EN
        ,
        .beat_lane  (beat_lane)
`endif
    );

    // Handshake: a pending result blocks input; ready is forced low in reset.
    assign in_ready  = reset_n && (state != HOLD);
    assign out_valid = (state == HOLD);
    assign beat_fire = in_valid && in_ready;

    // beat_count is 0 in IDLE, so a one-beat frame is also the last beat.
    assign last_beat = (beat_count == BEAT_W'(BEATS - 1));

    // The first beat of a frame always loads; later beats must win strictly,
    // which keeps the earliest frame position on ties across beats.
    assign take_beat = (state == IDLE) ||
                       is_greater(MAX_DATA_W'(beat_max), MAX_DATA_W'(acc_max),
                                  DATA_WIDTH, SIGNED != 0);
    assign next_max  = take_beat ? beat_max : acc_max;
`ifdef MAXI_ARGMAX_EN
    assign next_index = take_beat ?
                        (IDX_W'(beat_count) * IDX_W'(LANES) + IDX_W'(beat_lane)) :
                        acc_index;
`endif

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking assignment so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (beat_fire) state_next = last_beat ? HOLD : ACCUM;
            ACCUM:   if (beat_fire && last_beat) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat counter, running max and result registers.
    always_ff @(posedge clock) begin
        // NOTE: the accumulator is reset even though the first beat reloads
        // it, so outputs are deterministic from the first cycle after reset.
        if (!reset_n) begin
            beat_count <= '0;
            acc_max    <= '0;
            out_max    <= '0;
`ifdef MAXI_ARGMAX_EN
            acc_index  <= '0;
            out_index  <= '0;
`endif
        end else if (beat_fire) begin
            beat_count <= last_beat ? '0 : beat_count + 1'b1;
            acc_max    <= next_max;
`ifdef MAXI_ARGMAX_EN
            acc_index  <= next_index;
`endif
            if (last_beat) begin
                out_max   <= next_max;
`ifdef MAXI_ARGMAX_EN
                out_index <= next_index;
`endif
            end
        end
    end

endmodule

// File: tb/tb_stream_maxi.sv
// tb_stream_maxi: self-checking bench for stream_maxi. Three instances share
// one clock: unsigned and signed N=8/LANES=2/8-bit units fed the same beats,
// and an N=LANES=4 single-beat unit. Index checks apply when MAXI_ARGMAX_EN
// is defined.
module tb_stream_maxi;

    typedef logic [7:0] frame_t [8];

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        u_in_ready, u_out_valid;
    logic [7:0]  u_out_max;
    logic        s_in_ready, s_out_valid;
    logic [7:0]  s_out_max;
    logic        q_in_valid, q_out_ready;
    logic [31:0] q_in_data;
    logic        q_in_ready, q_out_valid;
    logic [7:0]  q_out_max;
`ifdef MAXI_ARGMAX_EN
    logic [2:0]  u_out_index, s_out_index;
    logic [1:0]  q_out_index;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    stream_maxi #(.N(8), .DATA_WIDTH(8), .LANES(2), .SIGNED(0)) dut_u (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .out_valid(u_out_valid), .out_ready(out_ready), .out_max(u_out_max)
`ifdef MAXI_ARGMAX_EN
        , .out_index(u_out_index)
`endif
    );

    stream_maxi #(.N(8), .DATA_WIDTH(8), .LANES(2), .SIGNED(1)) dut_s (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_max(s_out_max)
`ifdef MAXI_ARGMAX_EN
        , .out_index(s_out_index)
`endif
    );

    stream_maxi #(.N(4), .DATA_WIDTH(8), .LANES(4), .SIGNED(0)) dut_q (
        .clock(clock), .reset_n(reset_n), .in_valid(q_in_valid), .in_ready(q_in_ready),
        .in_data(q_in_data), .out_valid(q_out_valid), .out_ready(q_out_ready), .out_max(q_out_max)
`ifdef MAXI_ARGMAX_EN
        , .out_index(q_out_index)
`endif
    );

    // Reference: maximum of the first n samples, first position on ties.
    function automatic void ref_max(input frame_t f, input int n, input bit sgn,
                                    output logic [7:0] mx, output int idx);
        int best;
        int v;
        best = sgn ? int'($signed(f[0])) : int'(f[0]);
        idx  = 0;
        for (int i = 1; i < n; i++) begin
            v = sgn ? int'($signed(f[i])) : int'(f[i]);
            if (v > best) begin
                best = v;
                idx  = i;
            end
        end
        mx = f[idx];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives the four beats of an 8-sample frame with optional idle gaps.
    task automatic drive_frame(input frame_t f, input int gap_pct);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < 4 && $urandom_range(0, 99) < gap_pct; g++) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = {f[2*b+1], f[2*b]};
            n_checks++;
            if (u_in_ready !== 1'b1) $display("FAIL beat_ready b=%0d: got %b want 1", b, u_in_ready);
            else n_pass++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        q_in_valid = 1'b0; q_in_data = '0; q_out_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if ({u_in_ready, s_in_ready, q_in_ready} !== 3'b000)
            $display("FAIL reset_in_ready: got %b want 000", {u_in_ready, s_in_ready, q_in_ready});
        else n_pass++;
        n_checks++;
        if ({u_out_valid, s_out_valid, q_out_valid} !== 3'b000)
            $display("FAIL reset_out_valid: got %b want 000", {u_out_valid, s_out_valid, q_out_valid});
        else n_pass++;
        n_checks++;
        if ({u_out_max, s_out_max, q_out_max} !== 24'h0)
            $display("FAIL reset_out_max: got %h want 000000", {u_out_max, s_out_max, q_out_max});
        else n_pass++;
`ifdef MAXI_ARGMAX_EN
        n_checks++;
        if ({u_out_index, s_out_index, q_out_index} !== 8'h0)
            $display("FAIL reset_out_index: got %h want 00", {u_out_index, s_out_index, q_out_index});
        else n_pass++;
`endif
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({u_in_ready, s_in_ready, q_in_ready, u_out_valid} !== 4'b1110)
            $display("FAIL release_ready: got %b want 1110", {u_in_ready, s_in_ready, q_in_ready, u_out_valid});
        else n_pass++;
    endtask

    task automatic test_basic();
        frame_t f = '{8'd3, 8'd9, 8'd9, 8'd1, 8'd2, 8'd7, 8'd0, 8'd5};
        logic [7:0] emx;
        int eidx;
        out_ready = 1'b1;
        ref_max(f, 8, 1'b0, emx, eidx);
        drive_frame(f, 0);
        n_checks++;
        if (u_out_valid !== 1'b1 || u_out_max !== emx)
            $display("FAIL basic_max: got v=%b max=%0d want v=1 max=%0d", u_out_valid, u_out_max, emx);
        else n_pass++;
`ifdef MAXI_ARGMAX_EN
        n_checks++;
        if (u_out_index !== 3'(eidx)) $display("FAIL basic_index: got %0d want %0d", u_out_index, eidx);
        else n_pass++;
`endif
        tick();
        n_checks++;
        if (u_out_valid !== 1'b0) $display("FAIL basic_one_cycle: got %b want 0", u_out_valid);
        else n_pass++;
    endtask

    task automatic test_signed();
        frame_t tbl [2];
        logic [7:0] umx, smx;
        int uidx, sidx;
        for (int i = 0; i < 8; i++) begin
            tbl[0][i] = (i == 6) ? 8'hFF : 8'hF0;
            tbl[1][i] = (i == 2) ? 8'h7F : 8'h80;
        end
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            ref_max(tbl[t], 8, 1'b0, umx, uidx);
            ref_max(tbl[t], 8, 1'b1, smx, sidx);
            drive_frame(tbl[t], 0);
            n_checks++;
            if (u_out_valid !== 1'b1 || u_out_max !== umx)
                $display("FAIL unsigned_max t=%0d: got v=%b %h want v=1 %h", t, u_out_valid, u_out_max, umx);
            else n_pass++;
            n_checks++;
            if (s_out_valid !== 1'b1 || s_out_max !== smx)
                $display("FAIL signed_max t=%0d: got v=%b %h want v=1 %h", t, s_out_valid, s_out_max, smx);
            else n_pass++;
`ifdef MAXI_ARGMAX_EN
            n_checks++;
            if (u_out_index !== 3'(uidx) || s_out_index !== 3'(sidx))
                $display("FAIL sign_index t=%0d: got u=%0d s=%0d want u=%0d s=%0d",
                         t, u_out_index, s_out_index, uidx, sidx);
            else n_pass++;
`endif
            tick();
        end
    endtask

    task automatic test_backpressure();
        frame_t f, g;
        logic [7:0] emx;
        int eidx;
        for (int i = 0; i < 8; i++) begin
            f[i] = 8'($urandom_range(0, 200));
            g[i] = 8'($urandom_range(0, 200));
        end
        out_ready = 1'b0;
        ref_max(f, 8, 1'b0, emx, eidx);
        drive_frame(f, 0);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (u_out_valid !== 1'b1 || u_in_ready !== 1'b0 || u_out_max !== emx)
                $display("FAIL hold c=%0d: got v=%b rdy=%b max=%0d want v=1 rdy=0 max=%0d",
                         c, u_out_valid, u_in_ready, u_out_max, emx);
            else n_pass++;
`ifdef MAXI_ARGMAX_EN
            n_checks++;
            if (u_out_index !== 3'(eidx)) $display("FAIL hold_index c=%0d: got %0d want %0d", c, u_out_index, eidx);
            else n_pass++;
`endif
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (u_out_valid !== 1'b0 || u_in_ready !== 1'b1)
            $display("FAIL after_transfer: got v=%b rdy=%b want v=0 rdy=1", u_out_valid, u_in_ready);
        else n_pass++;
        ref_max(g, 8, 1'b0, emx, eidx);
        drive_frame(g, 0);
        n_checks++;
        if (u_out_valid !== 1'b1 || u_out_max !== emx)
            $display("FAIL next_frame: got v=%b max=%0d want v=1 max=%0d", u_out_valid, u_out_max, emx);
        else n_pass++;
`ifdef MAXI_ARGMAX_EN
        n_checks++;
        if (u_out_index !== 3'(eidx)) $display("FAIL next_index: got %0d want %0d", u_out_index, eidx);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_random();
        frame_t f;
        logic [7:0] umx, smx;
        int uidx, sidx, stalls;
        for (int fr = 0; fr < 10; fr++) begin
            for (int i = 0; i < 8; i++)
                f[i] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            ref_max(f, 8, 1'b0, umx, uidx);
            ref_max(f, 8, 1'b1, smx, sidx);
            out_ready = 1'b0;
            drive_frame(f, 50);
            stalls = $urandom_range(0, 3);
            for (int c = 0; c <= stalls; c++) begin
                n_checks++;
                if (u_out_valid !== 1'b1 || u_out_max !== umx || s_out_valid !== 1'b1 || s_out_max !== smx)
                    $display("FAIL rand_max fr=%0d: got u=%b/%h s=%b/%h want 1/%h 1/%h",
                             fr, u_out_valid, u_out_max, s_out_valid, s_out_max, umx, smx);
                else n_pass++;
`ifdef MAXI_ARGMAX_EN
                n_checks++;
                if (u_out_index !== 3'(uidx) || s_out_index !== 3'(sidx))
                    $display("FAIL rand_index fr=%0d: got u=%0d s=%0d want u=%0d s=%0d",
                             fr, u_out_index, s_out_index, uidx, sidx);
                else n_pass++;
`endif
                if (c == stalls) out_ready = 1'b1;
                tick();
            end
            n_checks++;
            if (u_out_valid !== 1'b0 || s_out_valid !== 1'b0)
                $display("FAIL rand_release fr=%0d: got u=%b s=%b want 0 0", fr, u_out_valid, s_out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        frame_t f = '{default: 8'd4};
        frame_t h = '{default: 8'd9};
        bit seen;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h0909;
        tick(); tick();
        in_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            seen |= u_out_valid;
            tick();
        end
        n_checks++;
        if (seen) $display("FAIL midframe_no_valid: got 1 want 0");
        else n_pass++;
        drive_frame(f, 0);
        n_checks++;
        if (u_out_valid !== 1'b1 || u_out_max !== 8'd4)
            $display("FAIL midframe_result: got v=%b max=%0d want v=1 max=4", u_out_valid, u_out_max);
        else n_pass++;
`ifdef MAXI_ARGMAX_EN
        n_checks++;
        if (u_out_index !== 3'd0) $display("FAIL midframe_index: got %0d want 0", u_out_index);
        else n_pass++;
`endif
        tick();
        n_checks++;
        if (u_out_valid !== 1'b0) $display("FAIL midframe_single: got %b want 0", u_out_valid);
        else n_pass++;
        out_ready = 1'b0;
        drive_frame(h, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (u_out_valid !== 1'b0 || u_out_max !== 8'd0 || u_in_ready !== 1'b1)
            $display("FAIL hold_reset: got v=%b max=%0d rdy=%b want v=0 max=0 rdy=1",
                     u_out_valid, u_out_max, u_in_ready);
        else n_pass++;
        out_ready = 1'b1;
    endtask

    task automatic test_single_beat();
        frame_t f;
        logic [7:0] emx;
        int eidx;
        q_out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++)
                f[i] = (t == 0) ? 8'(i < 4 ? (i == 0 ? 1 : (i == 3 ? 2 : 8)) : 0)
                                : 8'($urandom_range(0, 7));
            ref_max(f, 4, 1'b0, emx, eidx);
            q_in_valid = 1'b1;
            q_in_data  = {f[3], f[2], f[1], f[0]};
            n_checks++;
            if (q_in_ready !== 1'b1) $display("FAIL q_ready t=%0d: got %b want 1", t, q_in_ready);
            else n_pass++;
            tick();
            q_in_valid = 1'b0;
            n_checks++;
            if (q_out_valid !== 1'b1 || q_out_max !== emx)
                $display("FAIL q_result t=%0d: got v=%b max=%0d want v=1 max=%0d", t, q_out_valid, q_out_max, emx);
            else n_pass++;
`ifdef MAXI_ARGMAX_EN
            n_checks++;
            if (q_out_index !== 2'(eidx)) $display("FAIL q_index t=%0d: got %0d want %0d", t, q_out_index, eidx);
            else n_pass++;
`endif
            tick();
            n_checks++;
            if (q_out_valid !== 1'b0 || q_in_ready !== 1'b1)
                $display("FAIL q_release t=%0d: got v=%b rdy=%b want v=0 rdy=1", t, q_out_valid, q_in_ready);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_random();
        test_reset_midframe();
        test_single_beat();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
